apb_master_fsm: RTL and testbench
=================================

APB_MASTER_FSM -- requirements
Module: apb_master_fsm

Interface
REQ-001 SHALL have parameter dataWidth, default 32, APB/request data width (multiple of 8).
REQ-002 SHALL have parameter addrWidth, default 32, APB/request address width.
REQ-003 SHALL have parameter timeoutCycles, default 16, max ACCESS wait cycles; 0 = no timeout.
REQ-004 SHALL have port pclk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port preset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: upstream (AXI4-Lite side) command handshake.
REQ-007 SHALL have ports req_write in 1, req_addr in addrWidth, req_wdata in dataWidth, req_wstrb in dataWidth/8, req_prot in 3: command payload.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-009 SHALL have ports rsp_write out 1, rsp_rdata out dataWidth, rsp_slverr out 1: response payload.
REQ-010 SHALL have APB outputs psel 1, penable 1, pwrite 1, paddr addrWidth, pprot 3, pwdata dataWidth, pstrb dataWidth/8.
REQ-011 SHALL have APB inputs pready 1, prdata dataWidth, pslverr 1.

Function
REQ-012 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state register only.
REQ-013 IDLE: req_ready=1; on req_valid latch payload, go SETUP; no other state asserts req_ready.
REQ-014 SETUP: psel=1, penable=0, paddr/pwrite/pprot/pwdata/pstrb = latched payload; next cycle unconditionally ACCESS.
REQ-015 ACCESS: psel=1, penable=1; control/address/data unchanged from SETUP for whole access.
REQ-016 Reads SHALL drive pstrb=0 regardless of req_wstrb.
REQ-017 ACCESS with pready=1: capture pslverr; capture prdata for reads, rdata=0 for writes; go RESP; psel/penable drop on that edge.
REQ-018 Wait counter: cleared on entering ACCESS, +1 each ACCESS cycle with pready=0.
REQ-019 If timeoutCycles!=0 and counter==timeoutCycles with pready=0: abort, rsp_slverr=1, rsp_rdata=0, go RESP, psel/penable drop.
REQ-020 pready=1 in the timeout cycle SHALL take precedence (normal completion).
REQ-021 RESP: rsp_valid=1, payload stable until rsp_ready=1; then IDLE same edge.
REQ-022 pready/prdata/pslverr SHALL be ignored outside ACCESS.
REQ-023 Outside SETUP/ACCESS: psel=0, penable=0; paddr/pwdata/pstrb/pwrite/pprot hold last value.
REQ-024 Minimum transfer: req accept -> rsp_valid = 3 cycles (IDLE, SETUP, ACCESS); one outstanding transfer.

Reset
REQ-025 preset=1 SHALL immediately force IDLE, psel=0, penable=0, pwrite=0, paddr=0, pprot=0, pwdata=0, pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_write=0, counter=0.
REQ-026 Reset mid-SETUP/ACCESS/RESP SHALL abandon transfer with no response; req_ready=1 first edge after release.

Verification
REQ-027 Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, pready=1 at first ACCESS -> psel 2 cycles, penable 1 cycle, rsp_valid 3rd cycle, rsp_slverr=0, rsp_rdata=0.
REQ-028 Read addr 0x24, wstrb 0xF, pready after 3 wait cycles, prdata 0x12345678 -> pstrb=0, paddr stable 5 cycles, rsp_rdata=0x12345678.
REQ-029 Read, pready never, timeoutCycles=16 -> abort after 17 ACCESS cycles, rsp_slverr=1, rsp_rdata=0, psel=0 next cycle.
REQ-030 Write, pslverr=1 with pready=1, rsp_ready held 0 for 4 cycles -> rsp_valid/rsp_slverr=1 held 4 cycles, req_ready=0 throughout, IDLE after rsp_ready.
REQ-031 preset pulsed during ACCESS -> psel/penable/rsp_valid=0 immediately, no response, next request completes normally.

Source files
------------

// File: rtl/apb_master_fsm_if.sv
// apb_master_fsm_if: upstream command/response handshake plus APB bus signals
interface apb_master_fsm_if #(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [addrWidth-1:0]   req_addr;
  logic [dataWidth-1:0]   req_wdata;
  logic [dataWidth/8-1:0] req_wstrb;
  logic [2:0]             req_prot;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_write;
  logic [dataWidth-1:0]   rsp_rdata;
  logic                   rsp_slverr;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [addrWidth-1:0]   paddr;
  logic [2:0]             pprot;
  logic [dataWidth-1:0]   pwdata;
  logic [dataWidth/8-1:0] pstrb;
  logic                   pready;
  logic [dataWidth-1:0]   prdata;
  logic                   pslverr;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_prot, rsp_ready,
    input  pready, prdata, pslverr,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_slverr,
    output psel, penable, pwrite, paddr, pprot, pwdata, pstrb
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_prot, rsp_ready,
    output pready, prdata, pslverr,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_slverr,
    input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_fsm.sv
// apb_master_fsm: single-outstanding command-to-APB bridge with ACCESS wait timeout
module apb_master_fsm #(
  parameter int dataWidth     = 32,
  parameter int addrWidth     = 32,
  parameter int timeoutCycles = 16
) (
  input logic pclk,
  input logic preset,
  apb_master_fsm_if.master bus
);
  localparam int sw = dataWidth / 8;
  localparam int cw = timeoutCycles > 0 ? $clog2(timeoutCycles + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t               state_q, state_d;
  logic [cw-1:0]        cnt_q, cnt_d;
  logic                 pwrite_q, pwrite_d;
  logic [addrWidth-1:0] paddr_q, paddr_d;
  logic [2:0]           pprot_q, pprot_d;
  logic [dataWidth-1:0] pwdata_q, pwdata_d;
  logic [sw-1:0]        pstrb_q, pstrb_d;
  logic                 rsp_write_q, rsp_write_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_slverr_q, rsp_slverr_d;
  logic                 timeout;
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pprot_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rsp_write_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pprot_q      <= pprot_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      rsp_write_q  <= rsp_write_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end
  // a pready in the final allowed wait cycle still completes normally
  assign timeout = (timeoutCycles != 0) && (cnt_q == cw'(timeoutCycles)) && !bus.pready;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pprot_d      = pprot_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    rsp_write_d  = rsp_write_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d  = SETUP;
        pwrite_d = bus.req_write;
        paddr_d  = bus.req_addr;
        pprot_d  = bus.req_prot;
        pwdata_d = bus.req_wdata;
        pstrb_d  = bus.req_write ? bus.req_wstrb : '0;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: if (bus.pready || timeout) begin
        state_d      = RESP;
        rsp_write_d  = pwrite_q;
        rsp_slverr_d = bus.pready ? bus.pslverr : 1'b1;
        rsp_rdata_d  = (bus.pready && !pwrite_q) ? bus.prdata : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.psel       = state_q == SETUP || state_q == ACCESS;
  assign bus.penable    = state_q == ACCESS;
  assign bus.rsp_valid  = state_q == RESP;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pprot      = pprot_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pstrb      = pstrb_q;
  assign bus.rsp_write  = rsp_write_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_slverr = rsp_slverr_q;
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: directed literal checks plus randomized traffic against a transaction-level model
module tb_apb_master_fsm;
  localparam int T = 16;
  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;
  apb_master_fsm_if #(.dataWidth(32), .addrWidth(32)) bus();
  apb_master_fsm #(.dataWidth(32), .addrWidth(32), .timeoutCycles(T)) dut (
    .pclk(pclk), .preset(preset), .bus(bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a transfer is outstanding for `age` cycles (0 = setup), then a response waits for rsp_ready
  bit          m_busy, m_resp, m_write, m_rwrite, m_err;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_busy = 0; m_resp = 0; m_age = 0; m_write = 0; m_rwrite = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_strb = 0; m_prot = 0;
    end else if (m_resp) begin
      if (bus.rsp_ready) m_resp = 0;
    end else if (m_busy) begin
      if (m_age == 0) m_age = 1;
      else if (bus.pready) begin
        m_busy = 0; m_resp = 1; m_rwrite = m_write; m_err = bus.pslverr;
        m_rdata = m_write ? 32'h0 : bus.prdata;
      end else if (T != 0 && m_age - 1 == T) begin
        m_busy = 0; m_resp = 1; m_rwrite = m_write; m_err = 1; m_rdata = 0;
      end else m_age++;
    end else if (bus.req_valid) begin
      m_busy = 1; m_age = 0; m_write = bus.req_write; m_addr = bus.req_addr;
      m_wdata = bus.req_wdata; m_prot = bus.req_prot; m_strb = bus.req_write ? bus.req_wstrb : 4'h0;
    end
  end
  always @(negedge pclk) begin
    if (chk_en && !preset) begin
      chk("req_ready", bus.req_ready, !m_busy && !m_resp);
      chk("psel", bus.psel, m_busy);
      chk("penable", bus.penable, m_busy && m_age > 0);
      chk("pwrite", bus.pwrite, m_write);
      chk("paddr", bus.paddr, m_addr);
      chk("pprot", bus.pprot, m_prot);
      chk("pwdata", bus.pwdata, m_wdata);
      chk("pstrb", bus.pstrb, m_strb);
      chk("rsp_valid", bus.rsp_valid, m_resp);
      chk("rsp_write", bus.rsp_write, m_rwrite);
      chk("rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("rsp_slverr", bus.rsp_slverr, m_err);
    end
  end
  int          psel_n, pen_n, rv_at;
  bit          addr_ok, strb_nz, drop_ok, got_err, got_w;
  logic [31:0] got_rdata;
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int waits, input logic [31:0] rd, input bit se, input int hold);
    @(negedge pclk);
    bus.req_valid = 1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_wstrb = s;
    bus.req_prot = 3'h2; bus.rsp_ready = 0; bus.pready = 1; bus.prdata = rd; bus.pslverr = se;
    psel_n = 0; pen_n = 0; rv_at = 0; addr_ok = 1; strb_nz = 0; drop_ok = 0;
    @(negedge pclk);
    bus.req_valid = 0; bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_write = ~w;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) @(negedge pclk);
      psel_n += int'(bus.psel);
      pen_n += int'(bus.penable);
      if (bus.psel && bus.paddr != a) addr_ok = 0;
      if (bus.psel && bus.pstrb != 0) strb_nz = 1;
      if (bus.rsp_valid) begin
        rv_at = i; got_rdata = bus.rsp_rdata; got_err = bus.rsp_slverr; got_w = bus.rsp_write;
        drop_ok = !bus.psel && !bus.penable;
        break;
      end
      bus.pready = bus.penable ? (pen_n > waits) : 1'b1;
    end
    if (rv_at == 0) chk("rsp_timeout", 0, 1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_req_ready", bus.req_ready, 0);
      @(negedge pclk);
    end
    bus.rsp_ready = 1;
    @(negedge pclk);
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
    bus.rsp_ready = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_wstrb = 0;
    bus.req_prot = 0; bus.rsp_ready = 0; bus.pready = 1; bus.prdata = 32'hFFFF_FFFF; bus.pslverr = 1;
    #12;
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pstrb", bus.pstrb, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    @(negedge pclk);
    preset = 0;
    chk_en = 1;
    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 0, 0);
    chk("wr_psel_cycles", psel_n, 2);
    chk("wr_penable_cycles", pen_n, 1);
    chk("wr_rsp_at", rv_at, 3);
    chk("wr_slverr", got_err, 0);
    chk("wr_rdata", got_rdata, 0);
    chk("wr_rsp_write", got_w, 1);
    xfer(0, 32'h24, 32'h0BAD_F00D, 4'hF, 3, 32'h12345678, 0, 0);
    chk("rd_pstrb_zero", strb_nz, 0);
    chk("rd_paddr_stable", addr_ok, 1);
    chk("rd_psel_cycles", psel_n, 5);
    chk("rd_rsp_at", rv_at, 6);
    chk("rd_rdata", got_rdata, 32'h12345678);
    chk("rd_rsp_write", got_w, 0);
    xfer(0, 32'h80, 32'h0, 4'h3, 1000, 32'hCAFEBABE, 0, 0);
    chk("to_access_cycles", pen_n, 17);
    chk("to_rsp_at", rv_at, 19);
    chk("to_slverr", got_err, 1);
    chk("to_rdata", got_rdata, 0);
    chk("to_psel_drop", drop_ok, 1);
    xfer(1, 32'h30, 32'h01020304, 4'h5, 0, 32'h0, 1, 4);
    chk("err_slverr", got_err, 1);
    chk("err_drop", drop_ok, 1);
    @(negedge pclk);
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h44; bus.pready = 1;
    @(negedge pclk);
    bus.req_valid = 0; bus.pready = 0;
    @(negedge pclk);
    chk("rst_mid_penable", bus.penable, 1);
    #2 preset = 1;
    #1;
    chk("rst_mid_psel", bus.psel, 0);
    chk("rst_mid_penable0", bus.penable, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_paddr", bus.paddr, 0);
    @(negedge pclk);
    preset = 0;
    bus.pready = 1;
    @(negedge pclk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    chk("post_rst_rsp_valid", bus.rsp_valid, 0);
    xfer(1, 32'h50, 32'h55AA55AA, 4'hC, 1, 32'h0, 0, 1);
    chk("post_rst_rsp_at", rv_at, 4);
    chk("post_rst_slverr", got_err, 0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk);
      bus.req_valid = ($urandom % 3) != 0;
      bus.req_write = $urandom % 2;
      bus.req_addr = $urandom;
      bus.req_wdata = $urandom;
      bus.req_wstrb = 4'($urandom);
      bus.req_prot = 3'($urandom);
      bus.pready = ((c / 200) % 3 == 2) ? 1'b0 : (($urandom % 3) == 0);
      bus.prdata = $urandom;
      bus.pslverr = ($urandom % 4) == 0;
      bus.rsp_ready = $urandom % 2;
      if (c == 1500 || c == 2207) begin
        #3 preset = 1;
        #1 preset = 0;
      end
    end
    @(negedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
